// File: rtl/sq_drain_ctrl.sv
// Store-queue drain controller: turns ROB store retirements into credits and drains SQ head
// entries to the D-cache write port in program order. Optional watchdog: SQ_DRAIN_TIMEOUT_EN.
module sq_drain_ctrl #(
  parameter int ROB_IDX_WIDTH = 6,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SQ_DEPTH      = 16,
  parameter int COMMIT_WIDTH  = 2,
  parameter int TIMEOUT_CYC   = 256
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0] commit_store_cnt_i,
  input  logic                             sq_head_valid_i,
  input  logic [ROB_IDX_WIDTH-1:0]         sq_head_rob_tag_i,
  input  logic [ADDR_WIDTH-1:0]            sq_head_addr_i,
  input  logic [DATA_WIDTH-1:0]            sq_head_data_i,
  input  logic [DATA_WIDTH/8-1:0]          sq_head_be_i,
  output logic                             sq_pop_valid_o,
  output logic                             dc_req_valid_o,
  input  logic                             dc_req_ready_i,
  output logic [ADDR_WIDTH-1:0]            dc_req_addr_o,
  output logic [DATA_WIDTH-1:0]            dc_req_data_o,
  output logic [DATA_WIDTH/8-1:0]          dc_req_be_o,
  output logic [ROB_IDX_WIDTH-1:0]         dc_req_rob_tag_o,
  input  logic                             dc_resp_valid_i,
  output logic [$clog2(SQ_DEPTH+1)-1:0]    pending_cnt_o,
  output logic                             flush_safe_o,
  output logic [31:0]                      drained_cnt_o,
`ifdef SQ_DRAIN_TIMEOUT_EN
  output logic                             timeout_o,
`endif
  output logic [1:0]                       fsm_state_o
);

  localparam int PEND_W = $clog2(SQ_DEPTH+1);

  // Handshake: a request transfers on a cycle where dc_req_valid_o && dc_req_ready_i; valid is
  // never retracted before that. dc_resp_valid_i is honoured only in WAIT_RESP, at least one
  // cycle after the transfer, and causes a single-cycle sq_pop_valid_o.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t            state_q, state_d;
  logic [PEND_W-1:0] pending_q;
  logic [PEND_W:0]   pend_sum;
  logic [31:0]       drained_q;
  logic              pop;
  logic              timeout_hit;

  assign pop            = (state_q == WAIT_RESP) && dc_resp_valid_i;
  assign pend_sum       = {1'b0, pending_q} + (PEND_W+1)'(commit_store_cnt_i)
                          - (PEND_W+1)'(pop);
  assign sq_pop_valid_o = pop;
  assign dc_req_valid_o = (state_q == REQ);

  // Payload is forced to zero outside REQ so nothing stale leaks onto the port.
  assign dc_req_addr_o    = dc_req_valid_o ? sq_head_addr_i    : '0;
  assign dc_req_data_o    = dc_req_valid_o ? sq_head_data_i    : '0;
  assign dc_req_be_o      = dc_req_valid_o ? sq_head_be_i      : '0;
  assign dc_req_rob_tag_o = dc_req_valid_o ? sq_head_rob_tag_i : '0;

  assign pending_cnt_o = pending_q;
  assign flush_safe_o  = (pending_q == '0) && (state_q == IDLE);
  assign drained_cnt_o = drained_q;
  assign fsm_state_o   = state_q;

`ifdef SQ_DRAIN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC+1);
  logic [WD_W-1:0] wd_q;

  assign timeout_hit = (state_q == WAIT_RESP) && !dc_resp_valid_i
                       && (wd_q == WD_W'(TIMEOUT_CYC-1));
  assign timeout_o   = timeout_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q <= '0;
    end else if (state_q != WAIT_RESP) begin
      wd_q <= '0;
    end else if (!timeout_hit) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pending_q != '0 && sq_head_valid_i) state_d = REQ;
      end
      REQ: begin
        if (dc_req_ready_i) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (dc_resp_valid_i) begin
          state_d = (pend_sum != '0 && sq_head_valid_i) ? REQ : IDLE;
        end else if (timeout_hit) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      drained_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pend_sum[PEND_W-1:0];
      if (pop) drained_q <= drained_q + 32'd1;
    end
  end

  a_credit_range: assert property (@(posedge clk_i) disable iff (rst_i)
    pend_sum <= (PEND_W+1)'(SQ_DEPTH));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop && pending_q == '0));

endmodule

// File: tb/tb_sq_drain_ctrl.sv
// Directed bench for sq_drain_ctrl: SQ model, expected-request queue checked by a handshake
// monitor, plus directed checks of credits, pops and flush_safe.
module tb_sq_drain_ctrl;
  localparam int EW = 6 + 32 + 32 + 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  commit_store_cnt_i = '0;
  logic        sq_head_valid_i = 1'b0;
  logic [5:0]  sq_head_rob_tag_i = '0;
  logic [31:0] sq_head_addr_i = '0;
  logic [31:0] sq_head_data_i = '0;
  logic [3:0]  sq_head_be_i = '0;
  logic        sq_pop_valid_o;
  logic        dc_req_valid_o;
  logic        dc_req_ready_i = 1'b0;
  logic [31:0] dc_req_addr_o;
  logic [31:0] dc_req_data_o;
  logic [3:0]  dc_req_be_o;
  logic [5:0]  dc_req_rob_tag_o;
  logic        dc_resp_valid_i = 1'b0;
  logic [4:0]  pending_cnt_o;
  logic        flush_safe_o;
  logic [31:0] drained_cnt_o;
  logic [1:0]  fsm_state_o;
`ifdef SQ_DRAIN_TIMEOUT_EN
  logic        timeout_o;
`endif

  sq_drain_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .commit_store_cnt_i(commit_store_cnt_i),
    .sq_head_valid_i(sq_head_valid_i), .sq_head_rob_tag_i(sq_head_rob_tag_i),
    .sq_head_addr_i(sq_head_addr_i), .sq_head_data_i(sq_head_data_i),
    .sq_head_be_i(sq_head_be_i), .sq_pop_valid_o(sq_pop_valid_o),
    .dc_req_valid_o(dc_req_valid_o), .dc_req_ready_i(dc_req_ready_i),
    .dc_req_addr_o(dc_req_addr_o), .dc_req_data_o(dc_req_data_o),
    .dc_req_be_o(dc_req_be_o), .dc_req_rob_tag_o(dc_req_rob_tag_o),
    .dc_resp_valid_i(dc_resp_valid_i), .pending_cnt_o(pending_cnt_o),
    .flush_safe_o(flush_safe_o), .drained_cnt_o(drained_cnt_o),
`ifdef SQ_DRAIN_TIMEOUT_EN
    .timeout_o(timeout_o),
`endif
    .fsm_state_o(fsm_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned pop_cnt = 0;
  logic        pop_seen = 1'b0;
  logic [EW-1:0] sq_q[$];
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_head();
    if (sq_q.size() != 0) begin
      sq_head_valid_i = 1'b1;
      {sq_head_rob_tag_i, sq_head_addr_i, sq_head_data_i, sq_head_be_i} = sq_q[0];
    end else begin
      sq_head_valid_i = 1'b0;
      {sq_head_rob_tag_i, sq_head_addr_i, sq_head_data_i, sq_head_be_i} = '0;
    end
  endtask

  task automatic push_store(input logic [5:0] tag, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
    sq_q.push_back({tag, addr, data, be});
    exp_q.push_back({tag, addr, data, be});
    update_head();
  endtask

  task automatic tick();
    @(posedge clk_i);
    #3;
  endtask

  // SQ model: the head advances on the edge where the DUT pops.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (pop_seen && sq_q.size() != 0) void'(sq_q.pop_front());
      update_head();
    end
  end

  // scoreboard monitor: compares every request handshake, counts pops
  always @(negedge clk_i) begin
    pop_seen <= sq_pop_valid_o;
    if (sq_pop_valid_o) pop_cnt++;
    if (dc_req_valid_o && dc_req_ready_i) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL req_unexpected: got tag %0h addr %0h, expected no request",
                 dc_req_rob_tag_o, dc_req_addr_o);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({dc_req_rob_tag_o, dc_req_addr_o, dc_req_data_o, dc_req_be_o} !== e) begin
          n_bad++;
          $display("FAIL req_payload: got %0h expected %0h",
                   {dc_req_rob_tag_o, dc_req_addr_o, dc_req_data_o, dc_req_be_o}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset, single store
    tick(); tick();
    check("rst_req_valid", EW'(dc_req_valid_o), EW'(0));
    check("rst_pop", EW'(sq_pop_valid_o), EW'(0));
    check("rst_pending", EW'(pending_cnt_o), EW'(0));
    check("rst_flush_safe", EW'(flush_safe_o), EW'(1));
    check("rst_drained", EW'(drained_cnt_o), EW'(0));
    rst_i = 1'b0;
    dc_req_ready_i = 1'b1;
    tick();
    push_store(6'd1, 32'h100, 32'hDEADBEEF, 4'hF);
    commit_store_cnt_i = 2'd1;
    tick();
    commit_store_cnt_i = 2'd0;
    check("t1_valid_c1", EW'(dc_req_valid_o), EW'(0));
    check("t1_pending_c1", EW'(pending_cnt_o), EW'(1));
    tick();
    check("t1_valid_c2", EW'(dc_req_valid_o), EW'(1));
    tick();
    check("t1_pop_wait", EW'(sq_pop_valid_o), EW'(0));
    dc_resp_valid_i = 1'b1;
    #1;
    check("t1_pop_resp", EW'(sq_pop_valid_o), EW'(1));
    tick();
    dc_resp_valid_i = 1'b0;
    check("t1_pending", EW'(pending_cnt_o), EW'(0));
    check("t1_drained", EW'(drained_cnt_o), EW'(1));
    check("t1_flush_safe", EW'(flush_safe_o), EW'(1));
    check("t1_pops", EW'(pop_cnt), EW'(1));

    // 2: two commits in one cycle, back-to-back drain
    push_store(6'd2, 32'h200, 32'h11112222, 4'h3);
    push_store(6'd3, 32'h204, 32'h33334444, 4'hC);
    commit_store_cnt_i = 2'd2;
    tick();
    commit_store_cnt_i = 2'd0;
    tick();
    check("t2_req1", EW'(dc_req_valid_o), EW'(1));
    tick();
    dc_resp_valid_i = 1'b1;
    tick();
    dc_resp_valid_i = 1'b0;
    check("t2_req2_no_idle", EW'(dc_req_valid_o), EW'(1));
    check("t2_pending_mid", EW'(pending_cnt_o), EW'(1));
    tick();
    dc_resp_valid_i = 1'b1;
    tick();
    dc_resp_valid_i = 1'b0;
    check("t2_drained", EW'(drained_cnt_o), EW'(3));
    check("t2_pops", EW'(pop_cnt), EW'(3));
    check("t2_flush_safe", EW'(flush_safe_o), EW'(1));

    // 3: ready low for 5 cycles
    dc_req_ready_i = 1'b0;
    push_store(6'd4, 32'h300, 32'hCAFEF00D, 4'h5);
    commit_store_cnt_i = 2'd1;
    tick();
    commit_store_cnt_i = 2'd0;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) dc_req_ready_i = 1'b1;
      #1;
      check("t3_valid_held", EW'(dc_req_valid_o), EW'(1));
      check("t3_payload_held", {dc_req_rob_tag_o, dc_req_addr_o, dc_req_data_o, dc_req_be_o},
            {6'd4, 32'h300, 32'hCAFEF00D, 4'h5});
      check("t3_no_pop", EW'(sq_pop_valid_o), EW'(0));
      tick();
    end
    dc_resp_valid_i = 1'b1;
    tick();
    dc_resp_valid_i = 1'b0;
    check("t3_drained", EW'(drained_cnt_o), EW'(4));

    // 4: commit in the same cycle as a pop with pending=1
    push_store(6'd5, 32'h400, 32'h0000AAAA, 4'h1);
    push_store(6'd6, 32'h404, 32'h0000BBBB, 4'h2);
    commit_store_cnt_i = 2'd1;
    tick();
    commit_store_cnt_i = 2'd0;
    tick();
    tick();
    dc_resp_valid_i = 1'b1;
    commit_store_cnt_i = 2'd1;
    tick();
    dc_resp_valid_i = 1'b0;
    commit_store_cnt_i = 2'd0;
    check("t4_pending_stays", EW'(pending_cnt_o), EW'(1));
    check("t4_next_req", EW'(dc_req_valid_o), EW'(1));
    tick();
    dc_resp_valid_i = 1'b1;
    tick();
    dc_resp_valid_i = 1'b0;
    check("t4_pending", EW'(pending_cnt_o), EW'(0));
    check("t4_drained", EW'(drained_cnt_o), EW'(6));

    // 5: reset in WAIT_RESP, late response ignored
    push_store(6'd7, 32'h700, 32'h77777777, 4'hF);
    commit_store_cnt_i = 2'd1;
    tick();
    commit_store_cnt_i = 2'd0;
    tick();
    tick();
    check("t5_in_wait", EW'(fsm_state_o), EW'(2));
    check("t5_flush_unsafe", EW'(flush_safe_o), EW'(0));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    dc_resp_valid_i = 1'b1;
    #1;
    check("t5_late_pop", EW'(sq_pop_valid_o), EW'(0));
    tick();
    dc_resp_valid_i = 1'b0;
    check("t5_pending", EW'(pending_cnt_o), EW'(0));
    check("t5_idle", EW'(fsm_state_o), EW'(0));
    check("t5_drained", EW'(drained_cnt_o), EW'(0));
    check("t5_flush_safe", EW'(flush_safe_o), EW'(1));
    tick();
    check("t5_stay_idle", EW'(dc_req_valid_o), EW'(0));
    sq_q.delete();
    update_head();

`ifdef SQ_DRAIN_TIMEOUT_EN
    // 6: watchdog resend
    push_store(6'd8, 32'h800, 32'h88888888, 4'hF);
    exp_q.push_back({6'd8, 32'h800, 32'h88888888, 4'hF});
    commit_store_cnt_i = 2'd1;
    tick();
    commit_store_cnt_i = 2'd0;
    tick();
    tick();
    for (int i = 1; i < 8; i++) begin
      check("t6_no_timeout", EW'(timeout_o), EW'(0));
      tick();
    end
    check("t6_timeout", EW'(timeout_o), EW'(1));
    check("t6_no_pop", EW'(sq_pop_valid_o), EW'(0));
    tick();
    check("t6_resend", EW'(dc_req_valid_o), EW'(1));
    check("t6_resend_addr", EW'(dc_req_addr_o), EW'(32'h800));
    tick();
    dc_resp_valid_i = 1'b1;
    tick();
    dc_resp_valid_i = 1'b0;
    tick();
    check("t6_drained", EW'(drained_cnt_o), EW'(1));
    check("t6_pops", EW'(pop_cnt), EW'(7));
`endif

    tick();
    check("exp_q_empty", EW'(exp_q.size()), EW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
